// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the APB GPIO peripheral.
//   - register word indices (paddr[5:2]) for the eleven implemented registers
//   - APB data width
//   - per-pin interrupt mode type, plus helpers that derive the mode from the
//     ITYPE/IPOL/IBOTH bits and evaluate whether a pin raises an event.
package gpio_pkg;

  localparam int REG_W = 32;

  localparam logic [3:0] GPIO_GPO     = 4'd0;
  localparam logic [3:0] GPIO_GPO_SET = 4'd1;
  localparam logic [3:0] GPIO_GPO_CLR = 4'd2;
  localparam logic [3:0] GPIO_GPD     = 4'd3;
  localparam logic [3:0] GPIO_GPI     = 4'd4;
  localparam logic [3:0] GPIO_IE      = 4'd5;
  localparam logic [3:0] GPIO_ITYPE   = 4'd6;
  localparam logic [3:0] GPIO_IPOL    = 4'd7;
  localparam logic [3:0] GPIO_IBOTH   = 4'd8;
  localparam logic [3:0] GPIO_ISTAT   = 4'd9;
  localparam logic [3:0] GPIO_IMSK    = 4'd10;

  typedef enum logic [2:0] {
    IRQ_FALL,
    IRQ_RISE,
    IRQ_BOTH,
    IRQ_LOW,
    IRQ_HIGH
  } irq_mode_e;

  // Level mode ignores IBOTH; in edge mode IBOTH overrides the polarity bit.
  function automatic irq_mode_e irq_mode(input logic itype, input logic ipol,
                                         input logic iboth);
    irq_mode_e m;
    if (itype)      m = ipol ? IRQ_HIGH : IRQ_LOW;
    else if (iboth) m = IRQ_BOTH;
    else            m = ipol ? IRQ_RISE : IRQ_FALL;
    return m;
  endfunction

  // s is the synchronised pin, ps the same value one cycle earlier.
  function automatic logic pin_event(input irq_mode_e mode, input logic s,
                                     input logic ps);
    logic ev;
    case (mode)
      IRQ_FALL: ev = ~s & ps;
      IRQ_RISE: ev = s & ~ps;
      IRQ_BOTH: ev = s ^ ps;
      IRQ_LOW:  ev = ~s;
      IRQ_HIGH: ev = s;
      default:  ev = 1'b0;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: multi-flop synchroniser for the asynchronous pin inputs.
// Ports:
//   pclk   in   clock
//   preset in   synchronous active-high reset, clears every stage
//   d      in   W  raw pin inputs
//   s      out  W  synchronised value (last stage)
//   ps     out  W  s delayed by one more cycle, used for edge detection
module gpio_sync #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         pclk,
  input  logic         preset,
  input  logic [W-1:0] d,
  output logic [W-1:0] s,
  output logic [W-1:0] ps
);

  logic [W-1:0] chain [STAGES];

  // Shift the pins through the chain; ps trails the last stage by one cycle.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      ps <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      ps <= chain[STAGES-1];
    end
  end

  assign s = chain[STAGES-1];

endmodule

// File: rtl/gpio_apb_irq.sv
// gpio_apb_irq: APB3 GPIO peripheral with per-pin interrupts.
// Ports:
//   pclk, preset               clock, synchronous active-high reset
//   paddr[5:0]                 byte address, word index = paddr[5:2]
//   psel, penable, pwrite      APB control; zero wait states (pready = psel & penable)
//   pwdata[31:0], prdata[31:0] write / read data (prdata combinational from registers)
//   pready, pslverr            transfer done / error (bad index or write to a read-only reg)
//   irq                        registered OR of pending and enabled interrupts
//   gpi[GPIO_W-1:0]            asynchronous pin inputs
//   gpo[GPIO_W-1:0]            pin output values
//   gpd[GPIO_W-1:0]            pin directions, 1 = output
module gpio_apb_irq
  import gpio_pkg::*;
#(
  parameter int GPIO_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [5:0]        paddr,
  output logic [31:0]       prdata,
  input  logic [31:0]       pwdata,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  output logic              pready,
  output logic              pslverr,
  output logic              irq,
  input  logic [GPIO_W-1:0] gpi,
  output logic [GPIO_W-1:0] gpo,
  output logic [GPIO_W-1:0] gpd
);

  localparam int WARM  = SYNC_STAGES + 1;
  localparam int CNT_W = $clog2(WARM + 1);

  logic [3:0]        idx;
  logic              access;
  logic              bad_idx;
  logic              ro_write;
  logic              err;
  logic              wr_en;
  logic [GPIO_W-1:0] wdata;
  logic [GPIO_W-1:0] rd_bits;

  logic [GPIO_W-1:0] ie;
  logic [GPIO_W-1:0] itype;
  logic [GPIO_W-1:0] ipol;
  logic [GPIO_W-1:0] iboth;
  logic [GPIO_W-1:0] istat;
  logic [GPIO_W-1:0] istat_clr;
  logic [GPIO_W-1:0] evt;
  logic [GPIO_W-1:0] s;
  logic [GPIO_W-1:0] ps;

  logic [CNT_W-1:0]  warmcnt;
  logic              warm_done;

  // Address low bits and the unimplemented upper data bits carry no meaning.
  logic              unused_apb;
  assign unused_apb = ^{paddr[1:0], pwdata};

  // APB decode: zero wait states; errors leave all state untouched.
  assign idx      = paddr[5:2];
  assign access   = psel & penable;
  assign bad_idx  = (idx > GPIO_IMSK);
  assign ro_write = pwrite & ((idx == GPIO_GPI) | (idx == GPIO_IMSK));
  assign err      = bad_idx | ro_write;
  assign wr_en    = access & pwrite & ~err;
  assign wdata    = pwdata[GPIO_W-1:0];
  assign pready   = access;
  assign pslverr  = access & err;

  gpio_sync #(
    .W      (GPIO_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .pclk   (pclk),
    .preset (preset),
    .d      (gpi),
    .s      (s),
    .ps     (ps)
  );

  // Read mux. GPO_SET/GPO_CLR are write-only strobes and read as zero;
  // an erroring access always returns zero.
  always_comb begin
    rd_bits = '0;
    case (idx)
      GPIO_GPO:   rd_bits = gpo;
      GPIO_GPD:   rd_bits = gpd;
      GPIO_GPI:   rd_bits = s;
      GPIO_IE:    rd_bits = ie;
      GPIO_ITYPE: rd_bits = itype;
      GPIO_IPOL:  rd_bits = ipol;
      GPIO_IBOTH: rd_bits = iboth;
      GPIO_ISTAT: rd_bits = istat;
      GPIO_IMSK:  rd_bits = istat & ie;
      default:    rd_bits = '0;
    endcase
    prdata = err ? '0 : REG_W'(rd_bits);
  end

  // Plain read/write registers plus the atomic set/clear views of GPO.
  always_ff @(posedge pclk) begin
    if (preset) begin
      gpo   <= '0;
      gpd   <= '0;
      ie    <= '0;
      itype <= '0;
      ipol  <= '0;
      iboth <= '0;
    end else if (wr_en) begin
      case (idx)
        GPIO_GPO:     gpo   <= wdata;
        GPIO_GPO_SET: gpo   <= gpo | wdata;
        GPIO_GPO_CLR: gpo   <= gpo & ~wdata;
        GPIO_GPD:     gpd   <= wdata;
        GPIO_IE:      ie    <= wdata;
        GPIO_ITYPE:   itype <= wdata;
        GPIO_IPOL:    ipol  <= wdata;
        GPIO_IBOTH:   iboth <= wdata;
        default:      ;
      endcase
    end
  end

  // Warm-up counter: the synchroniser and its delayed copy start from zero,
  // so a pin already high at reset would look like a rising edge. Events
  // are held off until the chain has filled with real pin values.
  always_ff @(posedge pclk) begin
    if (preset)          warmcnt <= '0;
    else if (!warm_done) warmcnt <= warmcnt + CNT_W'(1);
  end

  assign warm_done = (warmcnt == CNT_W'(WARM));

  // Per-pin event detection, independent of IE.
  for (genvar i = 0; i < GPIO_W; i++) begin : g_pin
    irq_mode_e mode;
    assign mode   = irq_mode(itype[i], ipol[i], iboth[i]);
    assign evt[i] = warm_done & pin_event(mode, s[i], ps[i]);
  end

  assign istat_clr = (wr_en && (idx == GPIO_ISTAT)) ? wdata : '0;

  // Sticky status: a new event (or a level condition that still holds)
  // beats a write-one-to-clear arriving in the same cycle.
  always_ff @(posedge pclk) begin
    if (preset) istat <= '0;
    else        istat <= evt | (istat & ~istat_clr);
  end

  // Interrupt line registered from the current status and enables.
  always_ff @(posedge pclk) begin
    if (preset) irq <= 1'b0;
    else        irq <= |(istat & ie);
  end

endmodule

// File: tb/tb_gpio_apb_irq.sv
// tb_gpio_apb_irq: table-driven register checks, hand-timed interrupt
// sequences, and randomized traffic compared against a behavioural model.
module tb_gpio_apb_irq;
  import gpio_pkg::*;

  localparam int W  = 8;
  localparam int SS = 2;

  logic         pclk = 1'b0;
  logic         preset;
  logic [5:0]   paddr;
  logic [31:0]  prdata;
  logic [31:0]  pwdata;
  logic         psel, penable, pwrite;
  logic         pready, pslverr, irq;
  logic [W-1:0] gpi, gpo, gpd;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  gpio_apb_irq #(.GPIO_W(W), .SYNC_STAGES(SS)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .paddr   (paddr),
    .prdata  (prdata),
    .pwdata  (pwdata),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pready  (pready),
    .pslverr (pslverr),
    .irq     (irq),
    .gpi     (gpi),
    .gpo     (gpo),
    .gpd     (gpd)
  );

  // Behavioural model: registers as plain variables, the synchroniser as a
  // queue of past pin samples, interrupt rules evaluated per pin.
  logic [W-1:0] m_gpo, m_gpd, m_ie, m_itype, m_ipol, m_iboth, m_istat, m_ps;
  logic         m_irq;
  logic [W-1:0] pinq [$];
  int           m_live;

  function automatic logic modelErr(input logic [3:0] i, input logic wr);
    return (i > 4'd10) || (wr && (i == 4'd4 || i == 4'd10));
  endfunction

  function automatic logic [31:0] modelRead(input logic [3:0] i, input logic wr);
    logic [W-1:0] v;
    v = '0;
    if (!modelErr(i, wr)) begin
      case (i)
        4'd0:  v = m_gpo;
        4'd3:  v = m_gpd;
        4'd4:  v = pinq[0];
        4'd5:  v = m_ie;
        4'd6:  v = m_itype;
        4'd7:  v = m_ipol;
        4'd8:  v = m_iboth;
        4'd9:  v = m_istat;
        4'd10: v = m_istat & m_ie;
        default: v = '0;
      endcase
    end
    return 32'(v);
  endfunction

  task automatic modelStep();
    logic [W-1:0] sv, ev, clr, d;
    logic [3:0]   i;
    logic         rose, fell;
    if (preset) begin
      m_gpo = '0; m_gpd = '0; m_ie = '0; m_itype = '0; m_ipol = '0;
      m_iboth = '0; m_istat = '0; m_irq = 1'b0; m_ps = '0; m_live = 0;
      pinq.delete();
      for (int k = 0; k < SS; k++) pinq.push_back('0);
    end else begin
      sv  = pinq[0];
      ev  = '0;
      clr = '0;
      if (m_live >= SS + 1) begin
        for (int p = 0; p < W; p++) begin
          rose = sv[p] && !m_ps[p];
          fell = !sv[p] && m_ps[p];
          if (m_itype[p])      ev[p] = (sv[p] == m_ipol[p]);
          else if (m_iboth[p]) ev[p] = rose || fell;
          else                 ev[p] = m_ipol[p] ? rose : fell;
        end
      end
      m_irq = |(m_istat & m_ie);
      i = paddr[5:2];
      d = pwdata[W-1:0];
      if (psel && penable && pwrite && !modelErr(i, 1'b1)) begin
        case (i)
          4'd0: m_gpo   = d;
          4'd1: m_gpo   = m_gpo | d;
          4'd2: m_gpo   = m_gpo & ~d;
          4'd3: m_gpd   = d;
          4'd5: m_ie    = d;
          4'd6: m_itype = d;
          4'd7: m_ipol  = d;
          4'd8: m_iboth = d;
          4'd9: clr     = d;
          default: ;
        endcase
      end
      m_istat = ev | (m_istat & ~clr);
      m_ps = sv;
      pinq.push_back(gpi);
      void'(pinq.pop_front());
      m_live++;
    end
  endtask

  always @(posedge pclk) modelStep();

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic wr, input logic [5:0] a,
                              input logic [31:0] d, input logic [31:0] r,
                              input logic e);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp_rdata = r; v.exp_err = e;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic busIdle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    paddr = v.addr; pwdata = v.data; pwrite = v.wr;
    psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    #1;
    checkOutput($sformatf("vec%0d pready", n), 32'(pready), 32'd1);
    checkOutput($sformatf("vec%0d pslverr", n), 32'(pslverr), 32'(v.exp_err));
    if (!v.wr) checkOutput($sformatf("vec%0d prdata", n), prdata, v.exp_rdata);
    tick();
    busIdle();
  endtask

  task automatic apbWrite(input logic [3:0] i, input logic [31:0] d);
    paddr = {i, 2'b00}; pwdata = d; pwrite = 1'b1;
    psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    busIdle();
  endtask

  task automatic holdRead(input logic [3:0] i);
    paddr = {i, 2'b00}; pwrite = 1'b0; psel = 1'b1; penable = 1'b1;
    #1;
  endtask

  task automatic randomTick();
    if ($urandom_range(0, 2) == 0) gpi = gpi ^ (W'($urandom) & W'($urandom));
    tick();
    checkOutput("rand gpo", 32'(gpo), 32'(m_gpo));
    checkOutput("rand gpd", 32'(gpd), 32'(m_gpd));
    checkOutput("rand irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic randomAccess(input logic [3:0] i, input logic wr,
                              input logic [31:0] d);
    paddr = {i, 2'($urandom_range(0, 3))}; pwrite = wr; pwdata = d;
    psel = 1'b1; penable = 1'b0;
    randomTick();
    penable = 1'b1;
    #1;
    checkOutput("rand pready", 32'(pready), 32'd1);
    checkOutput("rand pslverr", 32'(pslverr), 32'(modelErr(i, wr)));
    if (!wr) checkOutput("rand prdata", prdata, modelRead(i, wr));
    randomTick();
    busIdle();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    preset = 1'b1; gpi = '0; paddr = '0; pwdata = '0;
    busIdle();
    repeat (3) tick();
    preset = 1'b0;
    tick();

    for (int r = 0; r <= 10; r++) vecs.push_back(mk(1'b0, 6'(r * 4), 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 6'h00, 32'h0000_00F0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 6'h04, 32'h0000_0003, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 6'h08, 32'h0000_0010, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 6'h00, 32'h0, 32'h0000_00E3, 1'b0));
    vecs.push_back(mk(1'b0, 6'h04, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 6'h08, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 6'h0C, 32'hFFFF_FF3C, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 6'h0C, 32'h0, 32'h0000_003C, 1'b0));
    vecs.push_back(mk(1'b0, 6'h0F, 32'h0, 32'h0000_003C, 1'b0));
    vecs.push_back(mk(1'b0, 6'h2C, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, 6'h10, 32'h0000_00AA, 32'h0, 1'b1));
    vecs.push_back(mk(1'b0, 6'h10, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 6'h28, 32'h0000_00FF, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, 6'h3C, 32'h0000_0055, 32'h0, 1'b1));
    vecs.push_back(mk(1'b0, 6'h3C, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, 6'h2C, 32'h0000_00FF, 32'h0, 1'b1));
    vecs.push_back(mk(1'b0, 6'h00, 32'h0, 32'h0000_00E3, 1'b0));
    vecs.push_back(mk(1'b0, 6'h28, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 6'h14, 32'h0000_00FF, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 6'h14, 32'h0, 32'h0000_00FF, 1'b0));
    vecs.push_back(mk(1'b1, 6'h14, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 6'h14, 32'h0, 32'h0, 1'b0));

    foreach (vecs[n]) applyStimulus(vecs[n], n);
    checkOutput("gpo pins", 32'(gpo), 32'h0000_00E3);
    checkOutput("gpd pins", 32'(gpd), 32'h0000_003C);

    $display("[TB] edge interrupt sequence");
    apbWrite(GPIO_IE, 32'h1);
    apbWrite(GPIO_IPOL, 32'h1);
    holdRead(GPIO_ISTAT);
    gpi = 8'h01;
    tick(); checkOutput("edge istat c1", prdata, 32'h0);
    tick(); checkOutput("edge istat c2", prdata, 32'h0);
    tick(); checkOutput("edge istat c3", prdata, 32'h1);
    checkOutput("edge irq c3", 32'(irq), 32'd0);
    tick(); checkOutput("edge irq c4", 32'(irq), 32'd1);
    apbWrite(GPIO_ISTAT, 32'h1);
    holdRead(GPIO_ISTAT);
    checkOutput("edge w1c istat", prdata, 32'h0);
    checkOutput("edge w1c irq hold", 32'(irq), 32'd1);
    tick(); checkOutput("edge w1c irq drop", 32'(irq), 32'd0);
    apbWrite(GPIO_IBOTH, 32'h1);
    holdRead(GPIO_ISTAT);
    gpi = 8'h00;
    tick(); tick(); checkOutput("both istat c2", prdata, 32'h0);
    tick(); checkOutput("both istat c3", prdata, 32'h1);
    apbWrite(GPIO_ISTAT, 32'hFF);

    $display("[TB] level interrupt sequence");
    gpi = 8'h08;
    repeat (4) tick();
    apbWrite(GPIO_ITYPE, 32'h08);
    holdRead(GPIO_ISTAT);
    checkOutput("level idle", prdata, 32'h0);
    gpi = 8'h00;
    repeat (3) tick();
    checkOutput("level active", prdata, 32'h8);
    apbWrite(GPIO_ISTAT, 32'h8);
    holdRead(GPIO_ISTAT);
    checkOutput("level w1c ignored", prdata, 32'h8);
    gpi = 8'h08;
    repeat (3) tick();
    checkOutput("level sticky", prdata, 32'h8);
    apbWrite(GPIO_ISTAT, 32'h8);
    holdRead(GPIO_ISTAT);
    checkOutput("level cleared", prdata, 32'h0);
    apbWrite(GPIO_ITYPE, 32'h0);

    $display("[TB] w1c and event collision");
    apbWrite(GPIO_IPOL, 32'h03);
    holdRead(GPIO_ISTAT);
    gpi = 8'h0A;
    repeat (4) tick();
    checkOutput("coll first rise", prdata, 32'h2);
    gpi = 8'h08;
    repeat (4) tick();
    checkOutput("coll fall ignored", prdata, 32'h2);
    gpi = 8'h0A;
    tick();
    paddr = {GPIO_ISTAT, 2'b00}; pwdata = 32'h2; pwrite = 1'b1;
    psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    busIdle();
    holdRead(GPIO_ISTAT);
    checkOutput("coll event wins", prdata, 32'h2);
    apbWrite(GPIO_ISTAT, 32'h2);
    holdRead(GPIO_ISTAT);
    checkOutput("coll later clear", prdata, 32'h0);

    $display("[TB] warm-up after reset with pins high");
    busIdle();
    preset = 1'b1; gpi = 8'hFF;
    repeat (3) tick();
    preset = 1'b0;
    paddr = {GPIO_IPOL, 2'b00}; pwdata = 32'hFF; pwrite = 1'b1;
    psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    busIdle();
    holdRead(GPIO_ISTAT);
    repeat (6) tick();
    checkOutput("warmup istat", prdata, 32'h0);
    holdRead(GPIO_IPOL);
    checkOutput("warmup ipol", prdata, 32'hFF);
    holdRead(GPIO_GPI);
    checkOutput("warmup gpi", prdata, 32'hFF);
    busIdle();

    $display("[TB] reset during transfer");
    apbWrite(GPIO_GPO, 32'h5A);
    apbWrite(GPIO_GPD, 32'hA5);
    paddr = {GPIO_GPO, 2'b00}; pwdata = 32'hFF; pwrite = 1'b1;
    psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1; preset = 1'b1;
    #1;
    checkOutput("midreset pready", 32'(pready), 32'd1);
    tick();
    checkOutput("midreset gpo", 32'(gpo), 32'h0);
    checkOutput("midreset gpd", 32'(gpd), 32'h0);
    checkOutput("midreset irq", 32'(irq), 32'd0);
    preset = 1'b0;
    busIdle();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      logic [3:0] ri;
      int gap;
      ri = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'($urandom_range(0, 10));
      randomAccess(ri, 1'($urandom_range(0, 1)), $urandom);
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) randomTick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
